// File: rtl/sorter_freq_stim_pkg.sv
// Shared constants and types for the merge-sorter frequency/soak stimulus generator.
package sorter_freq_stim_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_LFSR   = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_SHIFT3 = 2'd3
    } mode_e;

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0] GOLDEN    = 32'h9E37_79B9;

    // Right-shifting Galois step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/sorter_sig_compactor.sv
// MISR signature, output record counter and key-order checker for tree output.
module sorter_sig_compactor
    import sorter_freq_stim_pkg::*;
#(
    parameter int DATW = 64,
    parameter int KEYW = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            chk_en,
    input  logic [DATW-1:0] dot,
    input  logic            doten,
    output logic [DATW-1:0] sig,
    output logic [31:0]     ocnt,
    output logic            err,
    output logic            sig_par
);

    logic [KEYW-1:0] prev_key;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sig      <= '0;
            ocnt     <= '0;
            err      <= 1'b0;
            sig_par  <= 1'b0;
            prev_key <= '0;
        end else begin
            sig_par <= ^sig;
            if (doten) begin
                sig      <= {sig[DATW-2:0], sig[DATW-1] ^ sig[0]} ^ dot;
                ocnt     <= ocnt + 32'd1;
                prev_key <= dot[KEYW-1:0];
                // First record has no predecessor; equal keys are allowed.
                if (chk_en && ocnt != 32'd0 && dot[KEYW-1:0] < prev_key)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sorter_freq_stim.sv
// Stimulus generator (issue FSM, gap/way counters, data modes) feeding the merge sorter
// tree, plus the output compactor.
module sorter_freq_stim
    import sorter_freq_stim_pkg::*;
#(
    parameter int W_LOG = 10,
    parameter int P_LOG = 3,
    parameter int DATW  = 64,
    parameter int KEYW  = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [1:0]                MODE,
    input  logic [3:0]                GAP,
    input  logic [(1<<W_LOG)-1:0]     RDY,
    output logic [(DATW<<P_LOG)-1:0]  DIN,
    output logic                      DINEN,
    output logic [W_LOG-1:0]          DIN_IDX,
    input  logic [DATW-1:0]           DOT,
    input  logic                      DOTEN,
    output logic [DATW-1:0]           SIG,
    output logic [31:0]               OCNT,
    output logic                      ERR,
    output logic                      OUT
);

    localparam int NREC = 1 << P_LOG;
    localparam int DINW = DATW << P_LOG;

    mode_e           mode_q;
    logic [3:0]      gap_q;
    state_e          state, state_n;
    logic [3:0]      gap_cnt;
    logic [W_LOG-1:0] idx;
    logic [31:0]     lfsr;
    logic [31:0]     bcnt;
    logic            issue;
    logic            shift_mode;
    logic [DINW-1:0] beat_data;
    logic [DATW-1:0] rec;
    logic [KEYW-1:0] key;
    logic [P_LOG-1:0] rr;

    assign shift_mode = (mode_q == MODE_SHIFT) || (mode_q == MODE_SHIFT3);

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            ST_ISSUE: begin
                issue = RDY[idx];
                if (issue && gap_q != 4'd0)
                    state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (gap_cnt <= 4'd1)
                    state_n = ST_ISSUE;
            end
            default: state_n = ST_ISSUE;
        endcase
    end

    // Record r of a beat: key in the low KEYW bits, {way, r} payload above it.
    always_comb begin
        beat_data = '0;
        rec       = '0;
        key       = '0;
        rr        = '0;
        for (int r = 0; r < NREC; r++) begin
            rr = P_LOG'(r);
            if (mode_q == MODE_LFSR)
                key = KEYW'(lfsr + 32'(r) * GOLDEN);
            else
                key = KEYW'((bcnt << P_LOG) | 32'(rr));
            rec = '0;
            rec[KEYW-1:0]    = key;
            rec[DATW-1:KEYW] = (DATW-KEYW)'({idx, rr});
            beat_data[r*DATW +: DATW] = rec;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q  <= mode_e'(MODE);
            gap_q   <= GAP;
            state   <= ST_ISSUE;
            gap_cnt <= '0;
            idx     <= '0;
            lfsr    <= LFSR_SEED;
            bcnt    <= '0;
            DINEN   <= 1'b0;
            DIN_IDX <= '0;
            DIN     <= (MODE == 2'd0 || MODE == 2'd3) ? DINW'(1) : '0;
        end else begin
            state <= state_n;
            DINEN <= issue;
            if (state == ST_ISSUE)
                idx <= idx + W_LOG'(1);
            if (state == ST_IDLE)
                gap_cnt <= gap_cnt - 4'd1;
            if (issue) begin
                DIN_IDX <= idx;
                gap_cnt <= gap_q;
                lfsr    <= lfsr_step(lfsr);
                bcnt    <= bcnt + 32'd1;
                DIN     <= shift_mode ? (DIN << 1) : beat_data;
            end
        end
    end

    sorter_sig_compactor #(.DATW(DATW), .KEYW(KEYW)) u_cmp (
        .CLK     (CLK),
        .RST     (RST),
        .chk_en  (mode_q == MODE_COUNT),
        .dot     (DOT),
        .doten   (DOTEN),
        .sig     (SIG),
        .ocnt    (OCNT),
        .err     (ERR),
        .sig_par (OUT)
    );

endmodule

// File: tb/tb_sorter_freq_stim.sv
// Randomised bench for sorter_freq_stim against a beat-level reference model.
module tb_sorter_freq_stim;

    localparam int W_LOG = 2;
    localparam int P_LOG = 3;
    localparam int DATW  = 64;
    localparam int KEYW  = 32;
    localparam int NW    = 1 << W_LOG;
    localparam int NREC  = 1 << P_LOG;
    localparam int DINW  = DATW << P_LOG;

    localparam int RDY_ALL = 0, RDY_RAND = 1, RDY_1010 = 2, RDY_NONE = 3;

    logic             CLK, RST;
    logic [1:0]       MODE;
    logic [3:0]       GAP;
    logic [NW-1:0]    RDY;
    logic [DINW-1:0]  DIN;
    logic             DINEN;
    logic [W_LOG-1:0] DIN_IDX;
    logic [DATW-1:0]  DOT;
    logic             DOTEN;
    logic [DATW-1:0]  SIG;
    logic [31:0]      OCNT;
    logic             ERR, OUT;

    sorter_freq_stim #(.W_LOG(W_LOG), .P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW)) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .GAP(GAP), .RDY(RDY),
        .DIN(DIN), .DINEN(DINEN), .DIN_IDX(DIN_IDX),
        .DOT(DOT), .DOTEN(DOTEN), .SIG(SIG), .OCNT(OCNT), .ERR(ERR), .OUT(OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [DINW-1:0] got, input logic [DINW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state, advanced once per clock in beat/record terms.
    int              mode_r, gap_r;
    int              m_gap_left, m_way, m_n;
    logic [31:0]     m_lfsr;
    logic [DINW-1:0] m_din;
    int              m_didx;
    logic [63:0]     m_sig;
    logic [31:0]     m_ocnt, m_prev;
    logic            m_err, m_out;
    logic [63:0]     dot_q[$];

    function automatic logic [31:0] lfsr_ref(input logic [31:0] x);
        if (x[0]) return (x >> 1) ^ 32'h8020_0003;
        return x >> 1;
    endfunction

    function automatic logic [DINW-1:0] records(input int way);
        logic [DINW-1:0] d;
        logic [31:0] k;
        d = '0;
        for (int r = 0; r < NREC; r++) begin
            if (mode_r == 1) k = m_lfsr + 32'(r) * 32'h9E37_79B9;
            else             k = 32'(m_n * NREC + r);
            d[r*DATW +: DATW] = {32'(way * NREC + r), k};
        end
        return d;
    endfunction

    // Caller is at a negedge; returns at a negedge with RST released.
    task automatic do_reset(input int mode, input int gap);
        logic [DINW-1:0] din0;
        RST = 1'b1; MODE = 2'(mode); GAP = 4'(gap); DOTEN = 1'b0; RDY = '1;
        din0 = (mode == 0 || mode == 3) ? DINW'(1) : '0;
        @(posedge CLK); #1;
        chk("rst_dinen", DINEN, 0);   chk("rst_idx", DIN_IDX, 0);
        chk("rst_sig", SIG, 0);       chk("rst_ocnt", OCNT, 0);
        chk("rst_err", ERR, 0);       chk("rst_out", OUT, 0);
        chk("rst_din", DIN, din0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        MODE = 2'($urandom); GAP = 4'($urandom);   // must be ignored after reset
        mode_r = mode; gap_r = gap;
        m_gap_left = 0; m_way = 0; m_n = 0; m_lfsr = 32'hACE1_0001;
        m_din = din0; m_didx = 0;
        m_sig = '0; m_ocnt = '0; m_prev = '0; m_err = 1'b0; m_out = 1'b0;
    endtask

    task automatic run(input int ncyc, input int rdy_sel, input bit dot_rand);
        bit          exp_en;
        logic [31:0] k;
        for (int c = 0; c < ncyc; c++) begin
            case (rdy_sel)
                RDY_ALL:  RDY = '1;
                RDY_RAND: RDY = NW'($urandom);
                RDY_1010: RDY = 4'b1010;
                default:  RDY = '0;
            endcase
            if (dot_q.size() > 0) begin
                DOTEN = 1'b1; DOT = dot_q.pop_front();
            end else if (dot_rand) begin
                DOTEN = 1'($urandom);
                k = ($urandom_range(0, 15) == 0) ? m_prev - 32'd1 : m_prev + 32'($urandom_range(0, 2));
                DOT = {$urandom, k};
            end else begin
                DOTEN = 1'b0; DOT = {$urandom, $urandom};
            end
            exp_en = 1'b0;
            if (m_gap_left > 0) begin
                m_gap_left--;
            end else begin
                if (RDY[m_way]) begin
                    exp_en = 1'b1;
                    m_didx = m_way;
                    if (mode_r == 0 || mode_r == 3) m_din = m_din << 1;
                    else                            m_din = records(m_way);
                    m_lfsr = lfsr_ref(m_lfsr);
                    m_n++;
                    m_gap_left = gap_r;
                end
                m_way = (m_way + 1) % NW;
            end
            m_out = ^m_sig;
            if (DOTEN) begin
                if (mode_r == 2 && m_ocnt != 0 && DOT[31:0] < m_prev) m_err = 1'b1;
                m_prev = DOT[31:0];
                m_sig  = {m_sig[62:0], m_sig[63] ^ m_sig[0]} ^ DOT;
                m_ocnt = m_ocnt + 32'd1;
            end
            @(posedge CLK); #1;
            chk("dinen", DINEN, exp_en);
            chk("din_idx", DIN_IDX, m_didx);
            chk("din", DIN, m_din);
            chk("sig", SIG, m_sig);
            chk("ocnt", OCNT, m_ocnt);
            chk("err", ERR, m_err);
            chk("out", OUT, m_out);
            @(negedge CLK);
        end
        DOTEN = 1'b0;
    endtask

    initial begin
        RST = 1'b1; MODE = '0; GAP = '0; RDY = '1; DOT = '0; DOTEN = 1'b0;
        @(negedge CLK);
        // shift mode with one idle cycle between beats
        do_reset(0, 1); run(12, RDY_ALL, 0);
        // count mode back-to-back, then with ways 0 and 2 never ready
        do_reset(2, 0); run(20, RDY_ALL, 0);
        do_reset(2, 0); run(16, RDY_1010, 0);
        // ordering error is sticky; issue runs alongside
        do_reset(2, 0);
        dot_q = '{64'd5, 64'd5, 64'd9, 64'd3};
        run(6, RDY_NONE, 0);
        chk("err_sticky", ERR, 1);
        chk("ocnt_4", OCNT, 4);
        run(30, RDY_ALL, 1);
        // signature from zero with two records of 1
        do_reset(1, 0);
        dot_q = '{64'd1, 64'd1};
        run(4, RDY_ALL, 0);
        // reset in the middle of a gapped lfsr stream, then reseeded
        do_reset(1, 3); run(40, RDY_RAND, 1);
        do_reset(1, 3); run(30, RDY_RAND, 1);
        // shift pattern runs out to all-zero
        do_reset(3, 0); run(530, RDY_ALL, 0);
        for (int i = 0; i < 4; i++) begin
            do_reset($urandom_range(0, 3), $urandom_range(0, 3));
            run(80, RDY_RAND, 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
